lfsr_prng: RTL and testbench
============================

// Module: lfsr_prng
// PURPOSE
//  Parametrised Fibonacci LFSR pseudo-random source, successor of the fixed 17-bit generator.
//  Generalises width, tap mask and bits-per-cycle; adds seed reload, zero-lock recovery,
//  free-run/on-demand modes, a valid/ready output register and a measured-period report.
//  Feeds game/graphics logic that consumes random words under backpressure.
// PARAMETERS
//  WIDTH  17             LFSR state width (>=3)
//  TAPS   17'h12000      feedback mask; fb = ^(st & TAPS) (default = bits 16,13)
//  SEED   17'h0002B      reset/fallback seed, must be non-zero
//  OUT_W  8              rnd_data width (<=WIDTH), taken from st[OUT_W-1:0]
//  STEPS  1              LFSR shifts per advance (1..WIDTH), unrolled combinationally
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  en         in   1      generation enable; 0 freezes state and output load
//  mode       in   1      0 = free-run, 1 = on-demand
//  seed_load  in   1      load seed_in (priority over en)
//  seed_in    in   WIDTH  new seed
//  rnd_ready  in   1      consumer accepts rnd_data
//  rnd_valid  out  1      rnd_data holds an unconsumed word
//  rnd_data   out  OUT_W  random word
//  state_out  out  WIDTH  current LFSR state
//  wrap_tick  out  1      1-cycle pulse: state returned to start value
//  period_out out  WIDTH  advances from start to last wrap (0 = none yet)
//  lockup     out  1      1-cycle pulse: zero seed/state replaced by SEED
// BEHAVIOUR
//  Reset: st=SEED, start=SEED, rnd_valid=0, rnd_data=0, wrap_tick=0, lockup=0, cnt=0, period_out=0.
//  Step: st' = {st[WIDTH-2:0], ^(st & TAPS)}; one advance = STEPS steps in one cycle.
//  load = en & (!rnd_valid | rnd_ready); on load: rnd_data<=st[OUT_W-1:0] (pre-advance), rnd_valid<=1.
//  rnd_valid & rnd_ready & !load -> rnd_valid<=0. rnd_data stable while valid & !ready.
//  adv = en (mode 0) or load (mode 1). Mode 0 drops unconsumed words; mode 1 never skips a word.
//  Latency: first rnd_valid one cycle after en rises; first word = SEED[OUT_W-1:0].
//  seed_load: st<=start<=(seed_in==0 ? SEED : seed_in); lockup=1 if seed_in==0;
//    rnd_valid<=0, cnt<=0, wrap_tick<=0; en/load/adv ignored that cycle. period_out unchanged.
//  st==0 during run (bad TAPS): st<=SEED, start<=SEED, cnt<=0, lockup pulse; no word loaded.
//  Period: cnt increments on adv; when adv and st'==start: wrap_tick<=1, period_out<=cnt+1, cnt<=0.
//  cnt saturates at all-ones (non-returning TAPS/STEPS combinations).
//  No internal FSM beyond valid flag; states: EMPTY (valid=0) / FULL (valid=1).
//  Async reset mid-run: all outputs to reset values immediately, independent of clk.
// STRUCTURE
//  lfsr_pkg: default TAPS constants per WIDTH (8..32), mode_e {MODE_FREE, MODE_DEMAND}.
//  Sub-module lfsr_step (combinational single shift, WIDTH/TAPS params), STEPS-deep generate chain.
//  Top holds st, start, cnt, period, output register and pulse regs.
// TESTING (WIDTH=17, TAPS=17'h12000, SEED=17'h0002B, OUT_W=8)
//  Reset, en=1, mode=0, ready=1 -> rnd_data 0x2B,0x56,0xAC on cycles 1..3; state_out 0x00056 at cycle 1.
//  mode=1, ready=0 -> valid held, rnd_data=0x2B, state_out frozen 0x00056; ready=1 one cycle -> next word 0x56.
//  Free-run from SEED 131071 cycles -> single wrap_tick, period_out=17'h1FFFF, state_out=0x0002B.
//  seed_load=1, seed_in=0, en=1 -> state_out=0x0002B, lockup pulse, rnd_valid=0 next cycle.
//  STEPS=8 variant, one advance from SEED -> state_out=17'h02B00.
//  rst_n low mid-stream with clk stopped -> rnd_valid=0, state_out=0x0002B without a clock edge.

Source files
------------

// File: rtl/lfsr_prng_pkg.sv
// Shared types and constants for the parametrised Fibonacci LFSR generator.
// default_taps() returns known maximal-length feedback masks for widths 8..32.
package lfsr_prng_pkg;

  typedef enum logic {
    MODE_FREE   = 1'b0,
    MODE_DEMAND = 1'b1
  } mode_e;

  // Masks are bit positions (0-based) of the XOR taps, shift direction towards the MSB.
  function automatic logic [31:0] default_taps(input int unsigned width);
    logic [31:0] t;
    case (width)
      32'd8:   t = 32'h0000_00B8;
      32'd9:   t = 32'h0000_0110;
      32'd10:  t = 32'h0000_0240;
      32'd11:  t = 32'h0000_0500;
      32'd12:  t = 32'h0000_0829;
      32'd13:  t = 32'h0000_100D;
      32'd14:  t = 32'h0000_2015;
      32'd15:  t = 32'h0000_6000;
      32'd16:  t = 32'h0000_D008;
      32'd17:  t = 32'h0001_2000;
      32'd18:  t = 32'h0002_0400;
      32'd19:  t = 32'h0004_0023;
      32'd20:  t = 32'h0009_0000;
      32'd21:  t = 32'h0014_0000;
      32'd22:  t = 32'h0030_0000;
      32'd23:  t = 32'h0042_0000;
      32'd24:  t = 32'h00E1_0000;
      32'd25:  t = 32'h0120_0000;
      32'd26:  t = 32'h0200_0023;
      32'd27:  t = 32'h0400_0013;
      32'd28:  t = 32'h0900_0000;
      32'd29:  t = 32'h1400_0000;
      32'd30:  t = 32'h2000_0029;
      32'd31:  t = 32'h4800_0000;
      32'd32:  t = 32'h8020_0003;
      default: t = 32'h0000_0000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_prng_if.sv
// Random-word stream between the generator (master) and its consumer (slave).
interface lfsr_prng_if #(
  parameter int unsigned OUT_W = 8
);
  logic             rnd_valid;
  logic             rnd_ready;
  logic [OUT_W-1:0] rnd_data;

  modport master (output rnd_valid, output rnd_data, input rnd_ready);
  modport slave  (input rnd_valid, input rnd_data, output rnd_ready);
endinterface

// File: rtl/lfsr_prng_step.sv
// One combinational Fibonacci shift: new LSB is the parity of the tapped bits.
module lfsr_prng_step #(
  parameter int unsigned       WIDTH = 17,
  parameter logic [WIDTH-1:0]  TAPS  = 17'h12000
) (
  input  logic [WIDTH-1:0] st_i,
  output logic [WIDTH-1:0] st_o
);
  assign st_o = {st_i[WIDTH-2:0], ^(st_i & TAPS)};
endmodule

// File: rtl/lfsr_prng.sv
// Parametrised LFSR random source with seed reload, zero-lock recovery, a valid/ready
// output register and a measured period (advances from start value back to itself).
module lfsr_prng
  import lfsr_prng_pkg::*;
#(
  parameter int unsigned      WIDTH = 17,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(32'h0000_002B),
  parameter int unsigned      OUT_W = 8,
  parameter int unsigned      STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  lfsr_prng_if.master      rnd,
  output logic [WIDTH-1:0] state_out,
  output logic             wrap_tick,
  output logic [WIDTH-1:0] period_out,
  output logic             lockup
);

  localparam logic [0:0]       VLD_EMPTY = 1'b0;
  localparam logic [0:0]       VLD_FULL  = 1'b1;
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] st_q, st_d, start_q, start_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [0:0]       valid_q, valid_d;
  logic             wrap_q, wrap_d, lock_q, lock_d;

  logic [STEPS:0][WIDTH-1:0] chain_s;
  logic [WIDTH-1:0]          next_st_s, seed_sel_s, cnt_inc_s;
  logic                      load_s, adv_s, seed_zero_s;
  mode_e                     mode_s;

  assign chain_s[0] = st_q;

  genvar gi;
  generate
    for (gi = 0; gi < STEPS; gi++) begin : g_step
      lfsr_prng_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
      ) u_step (
        .st_i (chain_s[gi]),
        .st_o (chain_s[gi+1])
      );
    end
  endgenerate

  assign next_st_s   = chain_s[STEPS];
  assign mode_s      = mode_e'(mode);
  assign load_s      = en & (~valid_q[0] | rnd.rnd_ready);
  assign adv_s       = (mode_s == MODE_DEMAND) ? load_s : en;
  assign seed_zero_s = (seed_in == ZERO_W);
  assign seed_sel_s  = seed_zero_s ? SEED : seed_in;
  // Counter sticks at all-ones when the taps never return to the start value.
  assign cnt_inc_s   = (&cnt_q) ? cnt_q : cnt_q + ONE_W;

  // Next-state logic: seed reload beats zero recovery beats normal generation.
  always_comb begin
    st_d     = st_q;
    start_d  = start_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    data_d   = data_q;
    valid_d  = valid_q;
    wrap_d   = 1'b0;
    lock_d   = 1'b0;
    if (seed_load) begin
      st_d    = seed_sel_s;
      start_d = seed_sel_s;
      lock_d  = seed_zero_s;
      valid_d = VLD_EMPTY;
      cnt_d   = ZERO_W;
    end else if (st_q == ZERO_W) begin
      st_d    = SEED;
      start_d = SEED;
      cnt_d   = ZERO_W;
      lock_d  = 1'b1;
      if (valid_q[0] && rnd.rnd_ready) begin
        valid_d = VLD_EMPTY;
      end else begin
        valid_d = valid_q;
      end
    end else begin
      if (load_s) begin
        data_d  = st_q[OUT_W-1:0];
        valid_d = VLD_FULL;
      end else if (valid_q[0] && rnd.rnd_ready) begin
        valid_d = VLD_EMPTY;
      end else begin
        valid_d = valid_q;
      end
      if (adv_s) begin
        st_d = next_st_s;
        if (next_st_s == start_q) begin
          wrap_d   = 1'b1;
          period_d = cnt_inc_s;
          cnt_d    = ZERO_W;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end else begin
        st_d = st_q;
      end
    end
  end

  // State, output register and pulse flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= SEED;
      start_q  <= SEED;
      cnt_q    <= ZERO_W;
      period_q <= ZERO_W;
      data_q   <= {OUT_W{1'b0}};
      valid_q  <= VLD_EMPTY;
      wrap_q   <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      lock_q   <= lock_d;
    end
  end

  assign rnd.rnd_valid = valid_q[0];
  assign rnd.rnd_data  = data_q;
  assign state_out     = st_q;
  assign wrap_tick     = wrap_q;
  assign period_out    = period_q;
  assign lockup        = lock_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Scoreboard bench: a word-level reference model predicts outputs; monitors compare
// per-cycle register state and every consumed word independently of the stimulus.
module tb_lfsr_prng;

  localparam logic [16:0] SEED_A = 17'h0002B;
  localparam logic [31:0] TAPS_A = 32'h0001_2000;
  localparam logic [31:0] MAX_A  = 32'h0001_FFFF;

  logic clk = 1'b0;
  bit   clk_run = 1'b1;
  logic rst_n = 1'b0;

  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // Instance A: default configuration under random stimulus
  logic        en_a = 1'b0, mode_a = 1'b0, sl_a = 1'b0;
  logic [16:0] si_a = 17'h0;
  logic [16:0] state_a, per_a;
  logic        wrap_a, lock_a;
  lfsr_prng_if #(.OUT_W(8)) ifa ();

  lfsr_prng #(.WIDTH(17), .TAPS(17'h12000), .SEED(17'h0002B), .OUT_W(8), .STEPS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .seed_load(sl_a), .seed_in(si_a),
    .rnd(ifa.master), .state_out(state_a), .wrap_tick(wrap_a), .period_out(per_a), .lockup(lock_a));

  // Instance B: eight shifts per advance
  logic        en_b = 1'b0;
  logic [16:0] state_b, per_b;
  logic        wrap_b, lock_b;
  lfsr_prng_if #(.OUT_W(8)) ifb ();

  lfsr_prng #(.WIDTH(17), .TAPS(17'h12000), .SEED(17'h0002B), .OUT_W(8), .STEPS(8)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .mode(1'b0), .seed_load(1'b0), .seed_in(17'h0),
    .rnd(ifb.master), .state_out(state_b), .wrap_tick(wrap_b), .period_out(per_b), .lockup(lock_b));

  // Instance C: small maximal-length register so a full period fits in the run
  logic       en_c = 1'b0;
  logic [7:0] state_c, per_c;
  logic       wrap_c, lock_c;
  lfsr_prng_if #(.OUT_W(4)) ifc ();

  lfsr_prng #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .OUT_W(4), .STEPS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en_c), .mode(1'b0), .seed_load(1'b0), .seed_in(8'h00),
    .rnd(ifc.master), .state_out(state_c), .wrap_tick(wrap_c), .period_out(per_c), .lockup(lock_c));

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  typedef struct {
    int          tgt;
    logic [31:0] st;
    logic        vld;
    logic [7:0]  data;
    logic        wrap;
    logic        lock;
    logic [31:0] per;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] word_q[$];

  logic [31:0] m_st, m_start, m_cnt, m_period;
  logic        m_valid;
  logic [7:0]  m_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  function automatic logic [31:0] lf_adv(input logic [31:0] s, input logic [31:0] taps,
                                         input int w, input int steps);
    logic [31:0] r, mask;
    r    = s;
    mask = (32'h1 << w) - 32'h1;
    for (int i = 0; i < steps; i++) begin
      r = ((r << 1) | 32'($countones(r & taps) % 2)) & mask;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_st = 32'(SEED_A); m_start = 32'(SEED_A);
    m_cnt = 32'h0; m_period = 32'h0; m_valid = 1'b0; m_data = 8'h00;
  endtask

  // Apply one cycle of stimulus to A, predict its outcome, wait for the edge.
  task automatic drive(input logic e, input logic md, input logic sl,
                       input logic [16:0] si, input logic rdy);
    exp_t        x;
    logic [31:0] nst;
    logic        r, ld, ad;
    r = sl ? 1'b0 : rdy;
    en_a = e; mode_a = md; sl_a = sl; si_a = si; ifa.rnd_ready = r;
    x.wrap = 1'b0; x.lock = 1'b0;
    if (sl) begin
      nst = (si == 17'h0) ? 32'(SEED_A) : 32'(si);
      m_st = nst; m_start = nst;
      x.lock = (si == 17'h0);
      if (m_valid) void'(word_q.pop_back());
      m_valid = 1'b0; m_cnt = 32'h0;
    end else begin
      ld = e && (!m_valid || r);
      ad = md ? ld : e;
      if (ld) begin
        m_data = m_st[7:0];
        word_q.push_back(m_data);
        m_valid = 1'b1;
      end else if (m_valid && r) begin
        m_valid = 1'b0;
      end
      if (ad) begin
        nst = lf_adv(m_st, TAPS_A, 17, 1);
        m_st = nst;
        if (nst == m_start) begin
          x.wrap = 1'b1; m_period = m_cnt + 32'h1; m_cnt = 32'h0;
        end else if (m_cnt != MAX_A) begin
          m_cnt = m_cnt + 32'h1;
        end
      end
    end
    x.tgt = cyc_n + 1; x.st = m_st; x.vld = m_valid; x.data = m_data; x.per = m_period;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Per-cycle monitor: compares registered outputs against the tagged expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      cyc_n++;
      #1;
      if (exp_q.size() > 0 && exp_q[0].tgt == cyc_n) begin
        x = exp_q.pop_front();
        chk("state", 32'(state_a), x.st);
        chk("valid", 32'(ifa.rnd_valid), 32'(x.vld));
        chk("data", 32'(ifa.rnd_data), 32'(x.data));
        chk("wrap", 32'(wrap_a), 32'(x.wrap));
        chk("lockup", 32'(lock_a), 32'(x.lock));
        chk("period", 32'(per_a), x.per);
      end
    end
  end

  // Handshake monitor: every consumed word must be the oldest predicted word.
  initial forever begin
    @(negedge clk);
    if (ifa.rnd_valid === 1'b1 && ifa.rnd_ready === 1'b1) begin
      if (word_q.size() == 0) chk("word_unexpected", 32'(ifa.rnd_data), 32'hFFFF_FFFF);
      else chk("word", 32'(ifa.rnd_data), 32'(word_q.pop_front()));
    end
  end

  int wrap_cnt, wrap_at;
  logic md_r;

  initial begin
    ifa.rnd_ready = 1'b0;
    ifb.rnd_ready = 1'b1;
    ifc.rnd_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_state", 32'(state_a), 32'h0002B);
    chk("rst_valid", 32'(ifa.rnd_valid), 32'h0);
    chk("rst_data", 32'(ifa.rnd_data), 32'h0);
    chk("rst_period", 32'(per_a), 32'h0);
    chk("rst_pulses", {30'h0, wrap_a, lock_a}, 32'h0);

    // Free-run with consumer always ready
    en_b = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 17'h0, 1'b1);
    en_b = 1'b0;
    chk("c1_data", 32'(ifa.rnd_data), 32'h2B);
    chk("c1_state", 32'(state_a), 32'h00056);
    chk("steps8_state", 32'(state_b), 32'h02B00);
    chk("steps8_data", 32'(ifb.rnd_data), 32'h2B);
    drive(1'b1, 1'b0, 1'b0, 17'h0, 1'b1);
    chk("c2_data", 32'(ifa.rnd_data), 32'h56);
    drive(1'b1, 1'b0, 1'b0, 17'h0, 1'b1);
    chk("c3_data", 32'(ifa.rnd_data), 32'hAC);

    // On-demand under backpressure
    drive(1'b0, 1'b1, 1'b1, 17'h0002B, 1'b0);
    chk("reload_state", 32'(state_a), 32'h0002B);
    chk("reload_valid", 32'(ifa.rnd_valid), 32'h0);
    drive(1'b1, 1'b1, 1'b0, 17'h0, 1'b0);
    repeat (3) drive(1'b1, 1'b1, 1'b0, 17'h0, 1'b0);
    chk("hold_data", 32'(ifa.rnd_data), 32'h2B);
    chk("hold_state", 32'(state_a), 32'h00056);
    chk("hold_valid", 32'(ifa.rnd_valid), 32'h1);
    drive(1'b1, 1'b1, 1'b0, 17'h0, 1'b1);
    chk("demand_next", 32'(ifa.rnd_data), 32'h56);

    // Zero seed falls back to SEED
    drive(1'b1, 1'b0, 1'b1, 17'h0, 1'b1);
    chk("zseed_state", 32'(state_a), 32'h0002B);
    chk("zseed_lock", 32'(lock_a), 32'h1);
    chk("zseed_valid", 32'(ifa.rnd_valid), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 17'h0, 1'b0);
    chk("lock_pulse_end", 32'(lock_a), 32'h0);

    // Randomised run
    md_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      logic        sl;
      logic [16:0] si;
      if (i % 100 == 0) md_r = 1'($urandom_range(0, 1));
      sl = ($urandom_range(0, 63) == 0);
      si = ($urandom_range(0, 3) == 0) ? 17'h0 : 17'($urandom);
      drive(($urandom_range(0, 3) != 0), md_r, sl, si, 1'($urandom_range(0, 1)));
    end
    drive(1'b0, 1'b0, 1'b0, 17'h0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 17'h0, 1'b1);
    @(posedge clk); #2;
    chk("words_left", 32'(word_q.size()), 32'h0);
    chk("exp_left", 32'(exp_q.size()), 32'h0);

    // Full period on the 8-bit instance
    wrap_cnt = 0; wrap_at = 0;
    en_c = 1'b1;
    for (int k = 1; k <= 255; k++) begin
      @(posedge clk); #1;
      if (wrap_c === 1'b1) begin
        wrap_cnt++;
        wrap_at = k;
      end
    end
    en_c = 1'b0;
    chk("wrap_count", 32'(wrap_cnt), 32'd1);
    chk("wrap_at", 32'(wrap_at), 32'd255);
    chk("period_c", 32'(per_c), 32'd255);
    chk("state_c_wrapped", 32'(state_c), 32'h01);
    @(posedge clk); #1;
    chk("wrap_c_end", 32'(wrap_c), 32'h0);

    // Asynchronous reset with the clock stopped
    drive(1'b1, 1'b0, 1'b0, 17'h0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 17'h0, 1'b0);
    @(negedge clk);
    clk_run = 1'b0;
    #7;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ifa.rnd_valid), 32'h0);
    chk("arst_state", 32'(state_a), 32'h0002B);
    chk("arst_data", 32'(ifa.rnd_data), 32'h0);
    chk("arst_period_c", 32'(per_c), 32'h0);
    word_q.delete();
    model_reset();
    #4;
    rst_n = 1'b1;
    clk_run = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("exp_left_end", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
